// File: rtl/fetch_pc_if.sv
// fetch_pc_if -- bundle between the IF stage and its neighbours.
//
// Groups the hazard-unit controls, the redirect request from EX, the
// instruction-memory request/response pair and the IF/ID register outputs.
//
// Handshake (instruction memory): the stage raises imem_req with imem_addr
// and keeps both unchanged until it sees imem_ready=1 in a cycle where
// imem_req=1. That cycle completes the transfer and imem_rdata is sampled
// in it. imem_ready is ignored while imem_req=0. At most one request is in
// flight.
//
// Modports:
//   master - the fetch stage (drives imem_req/imem_addr and the IF/ID outputs)
//   slave  - the environment (hazard unit, EX redirect, instruction memory)
//
// fsm_state is a debug view of the stage's state register.
interface fetch_pc_if #(
  parameter int WL = 32
);
  logic          stall_f;
  logic          flush_d;
  logic          pc_src;
  logic [WL-1:0] pc_target;
  logic          imem_req;
  logic [WL-1:0] imem_addr;
  logic [WL-1:0] imem_rdata;
  logic          imem_ready;
  logic [WL-1:0] instr_d;
  logic [WL-1:0] pc_d;
  logic [WL-1:0] pc_plus4_d;
  logic          valid_d;
  logic          misalign_f;
  logic [1:0]    fsm_state;

  modport master (
    input  stall_f, flush_d, pc_src, pc_target, imem_rdata, imem_ready,
    output imem_req, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
           misalign_f, fsm_state
  );

  modport slave (
    output stall_f, flush_d, pc_src, pc_target, imem_rdata, imem_ready,
    input  imem_req, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
           misalign_f, fsm_state
  );
endinterface

// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage -- IF stage of the 5-stage MIPS pipeline.
//
// Owns the fetch PC, issues one instruction-memory read at a time, computes
// PC+4 (modulo 2^WL) and loads the IF/ID register. A one-entry skid buffer
// holds a response that arrives while the hazard unit stalls the stage.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_pc_if.master: stall_f, flush_d, pc_src, pc_target,
//          imem_req/imem_addr/imem_rdata/imem_ready, instr_d, pc_d,
//          pc_plus4_d, valid_d, misalign_f, fsm_state (debug)
//
// Build option: define MISALIGN_TRAP_EN to redirect misaligned targets to
// EXC_VEC and pulse misalign_f. Without it the low two target bits are
// dropped and misalign_f stays 0.
module fetch_pc_stage #(
  parameter int            WL       = 32,
  parameter logic [WL-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WL-1:0] EXC_VEC  = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        rst,
  fetch_pc_if.master  bus
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [1:0]    state_q, state_d;
  logic [WL-1:0] fpc_q, fpc_d;       // fetch PC, always the request address
  logic [WL-1:0] tgt_q, tgt_d;       // redirect PC parked while draining DROP
  logic [WL-1:0] skid_q, skid_d;
  logic [WL-1:0] id_instr_q, id_instr_d;
  logic [WL-1:0] id_pc_q, id_pc_d;
  logic [WL-1:0] id_pc4_q, id_pc4_d;
  logic          id_valid_q, id_valid_d;
  logic          mis_q, mis_d;

  logic [WL-1:0] pc_plus4;
  logic [WL-1:0] redir_pc;
  logic          misaligned;
  logic          req_active;
  logic          load;
  logic [WL-1:0] load_word;

  assign pc_plus4   = fpc_q + WL'(4);
  assign misaligned = |bus.pc_target[1:0];
  assign redir_pc   = (TRAP_EN && misaligned) ? EXC_VEC
                    : (bus.pc_target & ~{{(WL-2){1'b0}}, 2'b11});
  assign req_active = (state_q != S_HOLD);

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    tgt_d      = tgt_q;
    skid_d     = skid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;
    mis_d      = 1'b0;
    load       = 1'b0;
    load_word  = bus.imem_rdata;

    if (bus.pc_src) begin
      // Redirect wins over stall, flush and any response this cycle.
      id_valid_d = 1'b0;
      id_instr_d = '0;
      mis_d      = TRAP_EN && misaligned;
      if (req_active && !bus.imem_ready) begin
        // The old request is still in flight: keep presenting it until the
        // memory answers, then switch to the parked target.
        tgt_d   = redir_pc;
        state_d = S_DROP;
      end else begin
        fpc_d   = redir_pc;
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH, S_WAIT: begin
          if (bus.imem_ready) begin
            if (bus.stall_f) begin
              skid_d  = bus.imem_rdata;
              state_d = S_HOLD;
            end else begin
              load    = 1'b1;
              fpc_d   = pc_plus4;
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!bus.stall_f) begin
            load      = 1'b1;
            load_word = skid_q;
            fpc_d     = pc_plus4;
            state_d   = S_FETCH;
          end
        end
        S_DROP: begin
          if (bus.imem_ready) begin
            fpc_d   = tgt_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase

      // A flush kills the entry even when a load would have happened; the
      // PC movement above is unaffected.
      if (bus.flush_d) begin
        id_valid_d = 1'b0;
        id_instr_d = '0;
      end else if (load) begin
        id_valid_d = 1'b1;
        id_instr_d = load_word;
        id_pc_d    = fpc_q;
        id_pc4_d   = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fpc_q      <= RESET_PC;
      tgt_q      <= RESET_PC;
      skid_q     <= '0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      tgt_q      <= tgt_d;
      skid_q     <= skid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
      mis_q      <= mis_d;
    end
  end

  // Request is gated by rst so nothing is issued while reset is held.
  assign bus.imem_req   = !rst && req_active;
  assign bus.imem_addr  = fpc_q;
  assign bus.instr_d    = id_instr_q;
  assign bus.pc_d       = id_pc_q;
  assign bus.pc_plus4_d = id_pc4_q;
  assign bus.valid_d    = id_valid_q;
  assign bus.misalign_f = mis_q;
  assign bus.fsm_state  = state_q;

endmodule
